// File: rtl/sumcomp4_pkg.sv
// Shared types and constants for the sumcomp4 adder arbiter.
// Holds the controller state encoding, opcodes and the signed-overflow rule.
package sumcomp4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic       OP_ADD = 1'b0;
    localparam logic       OP_SUB = 1'b1;
    localparam logic [3:0] ONE    = 4'b0001;

    // Signed overflow judged from the latched operands and the final sum.
    function automatic logic ovf_calc(input logic op, input logic [3:0] x,
                                      input logic [3:0] y, input logic [3:0] r);
        logic same_sign;
        same_sign = (x[3] == y[3]);
        if (op == OP_SUB)
            return !same_sign && (r[3] != x[3]);
        else
            return same_sign && (r[3] != x[3]);
    endfunction

endpackage

// File: rtl/sumcomp4_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// When both request, the one that did not win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = (req0 && req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/sumcomp4_arbiter.sv
// Shares one external 4-bit adder between two requesters: round-robin grant,
// one adder pass for add, two for subtract, registered result and ack pulse.
module sumcomp4_arbiter
    import sumcomp4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         op0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic         op1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic [W-1:0] adder_x,
    output logic [W-1:0] adder_y,
    input  logic [W-1:0] adder_s,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         busy
);

    state_t         state;
    logic [W-1:0]   opx;
    logic [W-1:0]   opy;
    logic           op;
    logic           owner;
    logic           last_grant;

    logic           grant_valid;
    logic           grant_id;
    logic           op_sel;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        op_sel = grant_id ? op1 : op0;
        a_sel  = grant_id ? a1  : a0;
        b_sel  = grant_id ? b1  : b0;
    end

    // Adder inputs are registered one state ahead, so in EXEC2 adder_x
    // itself holds the first-pass partial sum (x + ~y).
    // NOTE: every register here is updated with <= so all next-state values
    // are computed from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            opx        <= '0;
            opy        <= '0;
            op         <= OP_ADD;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            adder_x    <= '0;
            adder_y    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        opx     <= a_sel;
                        opy     <= b_sel;
                        op      <= op_sel;
                        owner   <= grant_id;
                        adder_x <= a_sel;
                        adder_y <= (op_sel == OP_SUB) ? ~b_sel : b_sel;
                        busy    <= 1'b1;
                        state   <= EXEC1;
                    end
                end
                EXEC1: begin
                    if (op == OP_SUB) begin
                        adder_x <= adder_s;
                        adder_y <= ONE;
                        state   <= EXEC2;
                    end else begin
                        result  <= adder_s;
                        ovf     <= ovf_calc(op, opx, opy, adder_s);
                        adder_x <= '0;
                        adder_y <= '0;
                        ack0    <= ~owner;
                        ack1    <= owner;
                        state   <= DONE;
                    end
                end
                EXEC2: begin
                    result  <= adder_s;
                    ovf     <= ovf_calc(op, opx, opy, adder_s);
                    adder_x <= '0;
                    adder_y <= '0;
                    ack0    <= ~owner;
                    ack1    <= owner;
                    state   <= DONE;
                end
                DONE: begin
                    last_grant <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
